// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and encodings for the multi-cycle RV32I control path
// Contents: sequencer state enum, supported opcodes, ALU control codes,
// ALU operation classes and datapath mux select encodings.
package core_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_ALU_WB,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_INV = 3'b111;

    // Operation class handed from the FSM to the ALU decoder.
    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_FUNC = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALU operation class and func3 to an ALU control code
// Ports: alu_op (operation class from FSM), func3 (instruction[14:12]),
//        alu_control (ALU operation select).
module alu_decoder
    import core_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] func3,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNC: begin
                case (func3)
                    3'b000:  alu_control = ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_INV;
                endcase
            end
            default: alu_control = ALU_INV;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore-style multi-cycle sequencer for the RV32I datapath
// Inputs : clk, rst (async, active-high), op/func3/func7 from the instruction
//          register, alu_zero from the ALU, mem_ready from the shared memory port.
// Outputs: mem_req/mem_we/adr_source (memory port), ir_write/pc_write/reg_write
//          (write strobes), alu_src_a/alu_src_b/result_source/imm_source (mux
//          selects), alu_control (ALU operation), illegal (sticky bad-opcode flag).
module multicycle_control
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_source,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_source,
    output logic [2:0] alu_control,
    output logic [1:0] imm_source,
    output logic       illegal
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;

    // func7 travels with the instruction but no supported op decodes it.
    logic unused_func7;
    assign unused_func7 = ^func7;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .func3       (func3),
        .alu_control (alu_control)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_source    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_source = RES_ALUOUT;
        imm_source    = IMM_I;
        alu_op        = ALU_OP_ADD;

        case (state)
            S_FETCH: begin
                mem_req       = 1'b1;
                alu_src_a     = SRC_A_PC;
                alu_src_b     = SRC_B_FOUR;
                result_source = RES_ALU;
                // Mealy strobes: IR load and PC+4 only in the accepting cycle.
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut for BRANCH to use.
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_IMM;
                imm_source = IMM_B;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_R:         next_state = S_EXEC_R;
                    OP_BEQ:       next_state = S_BRANCH;
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                imm_source = (op == OP_SW) ? IMM_S : IMM_I;
                next_state = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req    = 1'b1;
                adr_source = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write     = 1'b1;
                result_source = RES_MEMDATA;
                next_state    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                adr_source = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_OP_FUNC;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write     = 1'b1;
                result_source = RES_ALUOUT;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = SRC_A_RS1;
                alu_src_b     = SRC_B_RS2;
                alu_op        = ALU_OP_SUB;
                result_source = RES_ALUOUT;
                pc_write      = alu_zero;
                next_state    = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // Reset parks the FSM in FETCH asynchronously; keep the port and
        // write strobes quiet for as long as reset is held.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic [6:0] func7 = 7'd0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_source, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_source, imm_source;
    logic [2:0] alu_control;
    logic       illegal;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .func3         (func3),
        .func7         (func7),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .adr_source    (adr_source),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_source (result_source),
        .alu_control   (alu_control),
        .imm_source    (imm_source),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] ADDI = 7'b0010011;

    localparam int FETCH = 0, DECODE = 1, MADDR = 2, MREAD = 3, MWB = 4;
    localparam int MWRITE = 5, EXECR = 6, ALUWB = 7, BRANCH = 8, TRAP = 9;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       zero;
        logic       ready;
        int         st;
        logic       ill;
        string      name;
    } vec_t;

    typedef struct {
        logic [17:0] exp;
        string       name;
        int          idx;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ir_pulses = 0;
    int   exp_ir_pulses = 0;

    // Expected outputs packed as
    // {mem_req, mem_we, adr_source, ir_write, pc_write, reg_write,
    //  alu_src_a, alu_src_b, result_source, alu_control, imm_source, illegal}
    function automatic logic [17:0] expect_out(vec_t v);
        logic       req, we, adr, ir, pc, rw;
        logic [1:0] sa, sbs, rs, imm;
        logic [2:0] ac;
        req = 0; we = 0; adr = 0; ir = 0; pc = 0; rw = 0;
        sa = 2'b00; sbs = 2'b00; rs = 2'b00; imm = 2'b00; ac = 3'b000;
        case (v.st)
            FETCH: begin
                req = 1; sbs = 2'b10; rs = 2'b10; ir = v.ready; pc = v.ready;
            end
            DECODE: begin sa = 2'b01; sbs = 2'b01; imm = 2'b10; end
            MADDR: begin
                sa = 2'b10; sbs = 2'b01; imm = (v.op == SW) ? 2'b01 : 2'b00;
            end
            MREAD:  begin req = 1; adr = 1; end
            MWB:    begin rw = 1; rs = 2'b01; end
            MWRITE: begin req = 1; we = 1; adr = 1; end
            EXECR: begin
                sa = 2'b10; sbs = 2'b00;
                case (v.f3)
                    3'b000:  ac = 3'b000;
                    3'b111:  ac = 3'b010;
                    3'b110:  ac = 3'b011;
                    default: ac = 3'b111;
                endcase
            end
            ALUWB:  begin rw = 1; rs = 2'b00; end
            BRANCH: begin sa = 2'b10; sbs = 2'b00; ac = 3'b001; pc = v.zero; end
            default: ;
        endcase
        if (v.rst) begin
            req = 0; we = 0; ir = 0; pc = 0; rw = 0;
        end
        return {req, we, adr, ir, pc, rw, sa, sbs, rs, ac, imm, v.ill};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f,
                       input logic z, input logic rd, input int st,
                       input logic ill, input string nm);
        vec_t v;
        v.rst = r; v.op = o; v.f3 = f; v.zero = z; v.ready = rd;
        v.st = st; v.ill = ill; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v, input int idx);
        sb_t e;
        @(posedge clk);
        #1;
        rst       = v.rst;
        op        = v.op;
        func3     = v.f3;
        alu_zero  = v.zero;
        mem_ready = v.ready;
        func7     = 7'($urandom);
        e.exp  = expect_out(v);
        e.name = v.name;
        e.idx  = idx;
        sb.push_back(e);
    endtask

    sb_t         cur;
    logic [17:0] act;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            act = {mem_req, mem_we, adr_source, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_source, alu_control, imm_source,
                   illegal};
            n_cmp++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %b required %b", cur.name, cur.idx,
                         act, cur.exp);
            end
            if (ir_write === 1'b1) ir_pulses++;
        end
    end

    initial begin
        // Reset, then lw with zero-wait memory (ready ignored outside mem states).
        add(1, LW, 0, 0, 1, FETCH,  0, "reset");
        add(0, LW, 0, 0, 1, FETCH,  0, "lw_fetch");
        add(0, LW, 0, 0, 1, DECODE, 0, "lw_decode");
        add(0, LW, 0, 0, 1, MADDR,  0, "lw_addr");
        add(0, LW, 0, 0, 1, MREAD,  0, "lw_read");
        add(0, LW, 0, 0, 1, MWB,    0, "lw_wb");
        // sw with one fetch wait and three write waits.
        add(0, SW, 0, 0, 0, FETCH,  0, "sw_fetch_wait");
        add(0, SW, 0, 0, 1, FETCH,  0, "sw_fetch");
        add(0, SW, 0, 0, 0, DECODE, 0, "sw_decode");
        add(0, SW, 0, 0, 0, MADDR,  0, "sw_addr");
        for (int i = 0; i < 3; i++) add(0, SW, 0, 0, 0, MWRITE, 0, "sw_write_wait");
        add(0, SW, 0, 0, 1, MWRITE, 0, "sw_write_ack");
        // R-type with each func3 class.
        foreach (vecs[i]) begin end
        begin
            logic [2:0] f3s [4];
            f3s[0] = 3'b111; f3s[1] = 3'b001; f3s[2] = 3'b110; f3s[3] = 3'b000;
            for (int i = 0; i < 4; i++) begin
                add(0, RT, f3s[i], 0, 1, FETCH,  0, "r_fetch");
                add(0, RT, f3s[i], 0, 0, DECODE, 0, "r_decode");
                add(0, RT, f3s[i], 0, 0, EXECR,  0, "r_exec");
                add(0, RT, f3s[i], 0, 0, ALUWB,  0, "r_wb");
            end
        end
        // beq taken and not taken.
        add(0, BEQ, 0, 1, 1, FETCH,  0, "beq_fetch");
        add(0, BEQ, 0, 1, 0, DECODE, 0, "beq_decode");
        add(0, BEQ, 0, 1, 0, BRANCH, 0, "beq_taken");
        add(0, BEQ, 0, 0, 1, FETCH,  0, "beq_fetch");
        add(0, BEQ, 0, 0, 0, DECODE, 0, "beq_decode");
        add(0, BEQ, 0, 0, 0, BRANCH, 0, "beq_not_taken");
        // Reset while a load waits on memory: request abandoned, no stale write.
        add(0, LW, 0, 0, 1, FETCH,  0, "lwr_fetch");
        add(0, LW, 0, 0, 0, DECODE, 0, "lwr_decode");
        add(0, LW, 0, 0, 0, MADDR,  0, "lwr_addr");
        add(0, LW, 0, 0, 0, MREAD,  0, "lwr_read_wait");
        add(0, LW, 0, 0, 0, MREAD,  0, "lwr_read_wait");
        add(1, LW, 0, 0, 1, FETCH,  0, "rst_mid_read");
        add(0, LW, 0, 0, 0, FETCH,  0, "post_rst_fetch");
        // Unsupported opcode: sticky trap for 20 cycles, cleared by reset.
        add(0, ADDI, 0, 0, 1, FETCH,  0, "trap_fetch");
        add(0, ADDI, 0, 1, 0, DECODE, 0, "trap_decode");
        for (int i = 0; i < 20; i++)
            add(0, ADDI, 3'(i), i[0], i[1], TRAP, 1, "trap_hold");
        add(1, ADDI, 0, 0, 1, FETCH,  0, "trap_reset");
        add(0, LW,   0, 0, 1, FETCH,  0, "after_trap_fetch");
        add(0, LW,   0, 0, 0, DECODE, 0, "after_trap_decode");

        foreach (vecs[i]) begin
            if (vecs[i].st == FETCH && vecs[i].ready && !vecs[i].rst)
                exp_ir_pulses++;
        end

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], i);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        n_cmp++;
        if (ir_pulses != exp_ir_pulses) begin
            n_fail++;
            $display("FAIL ir_write_count: got %0d required %0d", ir_pulses,
                     exp_ir_pulses);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core datapath. It replaces the single-cycle control path with a Moore-style FSM. It steps each instruction through fetch, decode, execute, memory and writeback over several cycles. A single memory port is shared between instruction and data accesses through a req/ready handshake. It drives every datapath mux select, register-file and PC write strobe, and ALU operation, and flags unsupported opcodes.

## Interface
- No parameters; instruction subset fixed: lw (0000011), sw (0100011), R-type add/and/or (0110011), beq (1100011).
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- op  in  7  instruction[6:0] from the instruction register
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]; carried, not decoded
- alu_zero  in  1  ALU result == 0, combinational from datapath
- mem_ready  in  1  memory accepted/completed the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier, valid only with mem_req
- adr_source  out  1  0 = PC, 1 = ALUOut register
- ir_write  out  1  load instruction register and old_pc
- pc_write  out  1  load PC from result mux
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- result_source  out  2  00 = ALUOut register, 01 = memory data register, 10 = ALU output direct
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 111 invalid
- imm_source  out  2  00 I, 01 S, 10 B
- illegal  out  1  sticky unsupported-opcode flag

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, ALU_WB, BRANCH, TRAP.
- FETCH
  - Outputs: mem_req=1, adr_source=0, alu_src_a=00, alu_src_b=10, alu add, result_source=10.
  - On mem_ready: pulse ir_write and pc_write (PC ← PC+4), then go to DECODE. Otherwise hold.
- DECODE
  - Computes the branch target: alu_src_a=01, alu_src_b=01, imm_source=10, add.
  - Next state by op: lw/sw → MEM_ADDR; R-type → EXEC_R; beq → BRANCH; any other opcode → TRAP.
- MEM_ADDR: rs1+imm (alu_src_a=10, alu_src_b=01, add). imm_source=00 for lw, 01 for sw. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_req=1, adr_source=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, result_source=01, then FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, adr_source=1. Hold until mem_ready, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00. alu_control from func3: 000 → 000, 111 → 010, 110 → 011, any other → 111. Next ALU_WB.
- ALU_WB: reg_write=1, result_source=00, then FETCH.
- BRANCH
  - Computes rs1−rs2: alu_src_a=10, alu_src_b=00, alu_control=001, result_source=00.
  - pc_write = alu_zero, so PC ← target held in ALUOut. Then FETCH.
- TRAP: terminal. All strobes 0, illegal=1. Left only by reset.
- Outputs not listed for a state are 0. alu_control defaults to 000.

## Timing
- Reset: state=FETCH, illegal=0. While rst is high, mem_req, mem_we, ir_write, pc_write and reg_write are all forced to 0. mem_req rises in the first cycle after rst deasserts.
- Handshake
  - mem_req, mem_we and adr_source stay stable from assertion until the cycle mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
  - Wait states extend FETCH, MEM_READ and MEM_WRITE indefinitely.
- Latency with zero-wait memory (mem_ready high on the first request cycle): lw 5 cycles, sw 4, R-type 4, beq 3.
- ir_write and pc_write in FETCH are Mealy on mem_ready: asserted only in the accepting cycle, exactly once per instruction.
- Reset mid-instruction: immediate return to FETCH. No reg_write or pc_write is issued in the reset cycle. A pending memory request is abandoned.
- Unsupported R-type func3 executes with alu_control=111 and still writes back; illegal is not set.

## Structure
- Shared package `core_pkg` holds:
  - the state enum
  - opcode constants
  - ALU control codes
  - alu_src_a, alu_src_b, result_source and imm_source select encodings.
- One sub-module, `alu_decoder`: combinational mapping from alu_op and func3 to alu_control, instantiated by this FSM.

## Test plan
- Reset then lw, mem_ready tied high → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. reg_write=1 with result_source=01 in cycle 5. ir_write and pc_write pulse once in cycle 1.
- sw with mem_ready delayed 3 cycles in MEM_WRITE → mem_req=1, mem_we=1 and adr_source=1 held stable for 4 cycles. Return to FETCH. reg_write never asserted.
- R-type func3=111 → alu_control=010 in EXEC_R, reg_write=1 in ALU_WB. func3=001 → alu_control=111, illegal stays 0.
- beq with alu_zero=1 → pc_write=1 in BRANCH. With alu_zero=0 → pc_write=0. Both return to FETCH after 3 cycles.
- op=0010011 → TRAP, illegal=1 and all strobes 0 for 20 cycles. Assert rst → illegal=0, FETCH.
- rst asserted during MEM_READ wait → outputs drop the same cycle. After release, mem_req=1 with adr_source=0 and no stale reg_write.
